stream_rr_arbiter: RTL and testbench

//  - Shares one downstream 32-bit AXI-Stream page link among NUM_IN upstream page outputs.
//  - Typical use: merging several rendering-page output streams (e.g. zculling/coloring partitions) onto one link.
//  - Round-robin grants, bounded bursts and idle-gap release give fair, starvation-free link use.
//  - Observes the pipeline's level-sensitive ap_start: new grants are issued only while ap_start=1.

---
 rtl/rendering_arb_pkg.sv | 19 +
 rtl/rr_priority_pick.sv | 26 ++
 rtl/stream_rr_arbiter.sv | 154 +++++++++++++++
 tb/tb_stream_rr_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rendering_arb_pkg.sv
// Shared types and constants for the rendering-page stream arbiter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package rendering_arb_pkg;

   localparam int DATA_W_DEF = 32;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   // Pointer value after reset: the last input is "most recently served",
   // so the rotating search starts at input 0.
   function automatic int RR_RESET_LAST(input int num_in);
      return num_in - 1;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating first-one search: first set req bit after 'last', wrapping modulo NUM_IN.
// Latency: purely combinational.
// Backpressure: none; the result is consumed by the caller in the same cycle.
module rr_priority_pick #(
   parameter int NUM_IN = 4,
   parameter int IDX_W  = $clog2(NUM_IN)
) (
   input  logic [NUM_IN-1:0] req,
   input  logic [IDX_W-1:0]  last,
   output logic              any,
   output logic [IDX_W-1:0]  idx
);

   // Scan last+1, last+2, ... (mod NUM_IN); the first requester found wins.
   always_comb begin
      any = 1'b0;
      idx = '0;
      for (int i = 1; i <= NUM_IN; i++) begin
         if (!any && req[(int'(last) + i) % NUM_IN]) begin
            any = 1'b1;
            idx = IDX_W'((int'(last) + i) % NUM_IN);
         end
      end
   end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter merging NUM_IN page streams onto one link; optional ARB_STATS_EN beat counters.
// Latency: grant decided in one IDLE cycle, then combinational pass-through; one bubble between grants.
// Backpressure: link TREADY is routed straight to the granted input; bursts end on MAX_BURST beats or IDLE_TO gap.
module stream_rr_arbiter
   import rendering_arb_pkg::*;
#(
   parameter int NUM_IN    = 4,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MAX_BURST = 16,
   parameter int IDLE_TO   = 4
) (
   input  logic                       ap_clk,
   input  logic                       ap_rst,
   input  logic                       ap_start,
   output logic                       ap_idle,
   input  logic [NUM_IN*DATA_W-1:0]   Input_V_TDATA,
   input  logic [NUM_IN-1:0]          Input_V_TVALID,
   output logic [NUM_IN-1:0]          Input_V_TREADY,
   output logic [DATA_W-1:0]          Output_1_V_TDATA,
   output logic                       Output_1_V_TVALID,
   input  logic                       Output_1_V_TREADY,
   output logic [$clog2(NUM_IN)-1:0]  grant_id
`ifdef ARB_STATS_EN
   ,
   output logic [NUM_IN*32-1:0]       stat_beats
`endif
);

   localparam int IDX_W  = $clog2(NUM_IN);
   localparam int BEAT_W = $clog2(MAX_BURST + 1);
   localparam int GAP_W  = $clog2(IDLE_TO + 1);

   arb_state_e        state_q, state_d;
   logic [IDX_W-1:0]  grant_q, grant_d;
   logic [IDX_W-1:0]  last_q, last_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic              pick_any;
   logic [IDX_W-1:0]  pick_idx;
   logic              gnt_vld;
   logic              beat_acc;

   rr_priority_pick #(
      .NUM_IN (NUM_IN),
      .IDX_W  (IDX_W)
   ) u_pick (
      .req  (Input_V_TVALID),
      .last (last_q),
      .any  (pick_any),
      .idx  (pick_idx)
   );

   assign gnt_vld  = Input_V_TVALID[grant_q];
   assign ap_idle  = (state_q == IDLE);
   assign grant_id = grant_q;

   // Next-state, counters and the granted-input pass-through mux.
   always_comb begin
      state_d           = state_q;
      grant_d           = grant_q;
      last_d            = last_q;
      beat_d            = beat_q;
      gap_d             = gap_q;
      Output_1_V_TDATA  = Input_V_TDATA[int'(grant_q)*DATA_W +: DATA_W];
      Output_1_V_TVALID = 1'b0;
      Input_V_TREADY    = '0;
      beat_acc          = 1'b0;
      case (state_q)
         IDLE: begin
            beat_d = '0;
            gap_d  = '0;
            if (ap_start && pick_any) begin
               grant_d = pick_idx;
               last_d  = pick_idx;
               state_d = BURST;
            end
         end
         BURST: begin
            // Handshakes are masked during reset so no beat slips through the reset cycle.
            if (!ap_rst) begin
               Output_1_V_TVALID       = gnt_vld;
               Input_V_TREADY[grant_q] = Output_1_V_TREADY;
               beat_acc                = gnt_vld & Output_1_V_TREADY;
               if (gnt_vld) begin
                  gap_d = '0;
                  if (Output_1_V_TREADY) begin
                     beat_d = beat_q + 1'b1;
                     if (beat_q == BEAT_W'(MAX_BURST - 1)) begin
                        state_d = IDLE;
                     end
                  end
               end else begin
                  gap_d = gap_q + 1'b1;
                  if (gap_q == GAP_W'(IDLE_TO - 1)) begin
                     state_d = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM and counter registers with synchronous reset.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= IDX_W'(RR_RESET_LAST(NUM_IN));
         beat_q  <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         beat_q  <= beat_d;
         gap_q   <= gap_d;
      end
   end

`ifdef ARB_STATS_EN
   logic [31:0] stat_q [NUM_IN];
   logic [31:0] stat_d [NUM_IN];

   // Saturating per-input count of accepted beats.
   always_comb begin
      for (int k = 0; k < NUM_IN; k++) begin
         stat_d[k] = stat_q[k];
         if (beat_acc && (grant_q == IDX_W'(k)) && (stat_q[k] != 32'hFFFF_FFFF)) begin
            stat_d[k] = stat_q[k] + 32'd1;
         end
      end
   end

   // Beat counter registers, cleared by reset.
   always_ff @(posedge ap_clk) begin
      for (int k = 0; k < NUM_IN; k++) begin
         if (ap_rst) begin
            stat_q[k] <= '0;
         end else begin
            stat_q[k] <= stat_d[k];
         end
      end
   end

   // Pack the counters onto the stats port, input k in slice k.
   always_comb begin
      for (int k = 0; k < NUM_IN; k++) begin
         stat_beats[k*32 +: 32] = stat_q[k];
      end
   end
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter: grant order, burst length, gap release, ap_start and reset.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: link ready is held high or toggled by the individual steps.
module tb_stream_rr_arbiter;

   localparam int NUM_IN = 4;
   localparam int DATA_W = 32;

   logic                     ap_clk = 1'b0;
   logic                     ap_rst;
   logic                     ap_start;
   logic                     ap_idle;
   logic [NUM_IN*DATA_W-1:0] in_dat;
   logic [NUM_IN-1:0]        in_vld;
   logic [NUM_IN-1:0]        in_rdy;
   logic [DATA_W-1:0]        out_dat;
   logic                     out_vld;
   logic                     out_rdy;
   logic [1:0]               grant_id;
`ifdef ARB_STATS_EN
   logic [NUM_IN*32-1:0]     stat_beats;
`endif

   always #5 ap_clk = ~ap_clk;

   stream_rr_arbiter #(
      .NUM_IN    (NUM_IN),
      .DATA_W    (DATA_W),
      .MAX_BURST (16),
      .IDLE_TO   (4)
   ) dut (
      .ap_clk            (ap_clk),
      .ap_rst            (ap_rst),
      .ap_start          (ap_start),
      .ap_idle           (ap_idle),
      .Input_V_TDATA     (in_dat),
      .Input_V_TVALID    (in_vld),
      .Input_V_TREADY    (in_rdy),
      .Output_1_V_TDATA  (out_dat),
      .Output_1_V_TVALID (out_vld),
      .Output_1_V_TREADY (out_rdy),
      .grant_id          (grant_id)
`ifdef ARB_STATS_EN
      ,
      .stat_beats        (stat_beats)
`endif
   );

   typedef struct {
      int gid;
      int beats;
      int cyc;
   } burst_t;

   int               n_cmp = 0;
   int               n_bad = 0;
   int               cyc = 0;
   int               seq [NUM_IN];
   int               lim [NUM_IN];
   logic [NUM_IN-1:0] vld_en;
   burst_t           bq[$];
   int               cur_beats, cur_gid;
   logic             prev_busy;
   logic             s_idle, s_out_acc, s_ovld;
   logic [1:0]       s_gid;
   logic [NUM_IN-1:0] s_acc, s_rdy;
   int               t0, nb;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int k = 0; k < NUM_IN; k++) begin
         in_dat[k*DATA_W +: DATA_W] = {8'(k), 24'(seq[k])};
         in_vld[k] = vld_en[k] && (seq[k] < lim[k]);
      end
   endtask

   // One clock: sample and check at the falling edge, then update stream models after the rising edge.
   task automatic cycle();
      @(negedge ap_clk);
      s_idle    = ap_idle;
      s_gid     = grant_id;
      s_rdy     = in_rdy;
      s_ovld    = out_vld;
      s_acc     = in_vld & in_rdy;
      s_out_acc = out_vld & out_rdy;
      chk("acc_onehot", longint'($countones(s_acc) <= 1), 1);
      chk("acc_link", longint'(|s_acc), longint'(s_out_acc));
      if (s_idle) chk("idle_quiet", longint'({in_rdy, out_vld}), 0);
      else        chk("rdy_other", longint'(in_rdy & ~(4'b0001 << s_gid)), 0);
      for (int k = 0; k < NUM_IN; k++) begin
         if (s_acc[k]) chk("beat_data", longint'(out_dat), longint'({8'(k), 24'(seq[k])}));
      end
      if (!s_idle) begin
         cur_gid   = int'(s_gid);
         cur_beats = cur_beats + int'(s_out_acc);
         prev_busy = 1'b1;
      end else if (prev_busy) begin
         bq.push_back('{cur_gid, cur_beats, cyc});
         cur_beats = 0;
         prev_busy = 1'b0;
      end
      @(posedge ap_clk);
      #1;
      for (int k = 0; k < NUM_IN; k++) begin
         if (s_acc[k]) seq[k]++;
      end
      drive();
      cyc++;
   endtask

   task automatic do_reset();
      ap_rst   = 1'b1;
      ap_start = 1'b0;
      out_rdy  = 1'b0;
      vld_en   = '0;
      drive();
      cycle();
      ap_rst = 1'b0;
      for (int k = 0; k < NUM_IN; k++) begin
         seq[k] = 0;
         lim[k] = 1 << 30;
      end
      drive();
      bq.delete();
      cur_beats = 0;
      prev_busy = 1'b0;
      chk("rst_idle", longint'(ap_idle), 1);
      chk("rst_gid", longint'(grant_id), 0);
      chk("rst_rdy", longint'(in_rdy), 0);
      chk("rst_ovld", longint'(out_vld), 0);
   endtask

   initial begin
      for (int k = 0; k < NUM_IN; k++) begin
         seq[k] = 0;
         lim[k] = 1 << 30;
      end
      cur_beats = 0;
      cur_gid   = 0;
      prev_busy = 1'b0;
      vld_en    = '0;
      out_rdy   = 1'b0;
      ap_start  = 1'b0;
      ap_rst    = 1'b1;
      drive();

      // T1: single stream, 100 beats in order, 16-beat bursts with a bubble.
      do_reset();
      ap_start = 1'b1; out_rdy = 1'b1; vld_en = 4'b0001; drive();
      t0 = cyc;
      cycle();
      chk("t1_c0_idle", longint'(s_idle), 1);
      chk("t1_c0_noacc", longint'(s_out_acc), 0);
      cycle();
      chk("t1_c1_busy", longint'(s_idle), 0);
      chk("t1_c1_gid", longint'(s_gid), 0);
      chk("t1_c1_acc", longint'(s_out_acc), 1);
      while (seq[0] < 100 && cyc - t0 < 200) cycle();
      chk("t1_beats", seq[0], 100);
      chk("t1_cycles", cyc - t0, 107);
      chk("t1_nburst", bq.size(), 6);
      for (int i = 0; i < bq.size() && i < 6; i++) begin
         chk("t1_bgid", bq[i].gid, 0);
         chk("t1_blen", bq[i].beats, 16);
         chk("t1_bend", bq[i].cyc - t0, 17 * (i + 1));
      end

      // T2: all four streams valid, order 0,1,2,3,0 with a 17-cycle period.
      do_reset();
      ap_start = 1'b1; out_rdy = 1'b1; vld_en = 4'b1111; drive();
      t0 = cyc;
      repeat (86) cycle();
      chk("t2_nburst", bq.size(), 5);
      for (int i = 0; i < bq.size() && i < 5; i++) begin
         chk("t2_bgid", bq[i].gid, i % 4);
         chk("t2_blen", bq[i].beats, 16);
         chk("t2_bend", bq[i].cyc - t0, 17 * (i + 1));
      end

      // T3: link ready toggles; bursts still carry 16 beats, no gap release.
      do_reset();
      ap_start = 1'b1; out_rdy = 1'b1; vld_en = 4'b0011; drive();
      t0 = cyc;
      while (bq.size() < 3 && cyc - t0 < 300) begin
         cycle();
         out_rdy = ~out_rdy;
      end
      chk("t3_nburst", bq.size(), 3);
      for (int i = 0; i < bq.size() && i < 3; i++) begin
         chk("t3_bgid", bq[i].gid, i % 2);
         chk("t3_blen", bq[i].beats, 16);
      end
      if (bq.size() > 0) chk("t3_bend0", bq[0].cyc - t0, 33);

      // T4: in2 sends 5 beats then goes quiet; after 4 low cycles in3 is granted.
      do_reset();
      ap_start = 1'b1; out_rdy = 1'b1; vld_en = 4'b1100; lim[2] = 5; drive();
      t0 = cyc;
      while (bq.size() < 1 && cyc - t0 < 50) cycle();
      chk("t4_nburst", bq.size(), 1);
      if (bq.size() > 0) begin
         chk("t4_bgid", bq[0].gid, 2);
         chk("t4_blen", bq[0].beats, 5);
         chk("t4_bend", bq[0].cyc - t0, 10);
      end
      cycle();
      chk("t4_gid3", longint'(s_gid), 3);
      chk("t4_busy", longint'(s_idle), 0);
      chk("t4_acc", longint'(s_out_acc), 1);

      // T5: ap_start drops after beat 3; burst completes, then no regrant until restored.
      do_reset();
      ap_start = 1'b1; out_rdy = 1'b1; vld_en = 4'b0011; drive();
      t0 = cyc;
      repeat (4) cycle();
      chk("t5_beats3", seq[0], 3);
      ap_start = 1'b0;
      while (bq.size() < 1 && cyc - t0 < 60) cycle();
      chk("t5_nburst", bq.size(), 1);
      if (bq.size() > 0) begin
         chk("t5_blen", bq[0].beats, 16);
         chk("t5_bend", bq[0].cyc - t0, 17);
      end
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("t5_hold_idle", longint'(s_idle), 1);
         chk("t5_hold_noacc", longint'(s_out_acc), 0);
      end
      ap_start = 1'b1;
      cycle();
      chk("t5_regrant_idle", longint'(s_idle), 1);
      cycle();
      chk("t5_regrant_gid", longint'(s_gid), 1);
      chk("t5_regrant_acc", longint'(s_out_acc), 1);

      // T6: one-cycle reset at beat 7 of in3's burst; restart from input 0.
      do_reset();
      ap_start = 1'b1; out_rdy = 1'b1; vld_en = 4'b1111; drive();
      t0 = cyc;
      repeat (58) cycle();
      chk("t6_pre_gid", longint'(s_gid), 3);
      chk("t6_pre_beats", seq[3], 6);
      ap_rst = 1'b1;
      cycle();
      chk("t6_rstcyc_rdy", longint'(s_rdy), 0);
      chk("t6_rstcyc_vld", longint'(s_ovld), 0);
      ap_rst = 1'b0;
      cycle();
      chk("t6_after_idle", longint'(s_idle), 1);
      chk("t6_after_rdy", longint'(s_rdy), 0);
      chk("t6_after_vld", longint'(s_ovld), 0);
      chk("t6_beats_kept", seq[3], 6);
`ifdef ARB_STATS_EN
      chk("t6_stat_clr", longint'(stat_beats[3*32 +: 32]), 0);
`endif
      cycle();
      chk("t6_new_gid", longint'(s_gid), 0);
      chk("t6_new_acc", longint'(s_out_acc), 1);
      nb = bq.size();
      if (nb > 0) begin
         chk("t6_abort_gid", bq[nb-1].gid, 3);
         chk("t6_abort_len", bq[nb-1].beats, 6);
      end
      while (bq.size() == nb && cyc - t0 < 120) cycle();
      chk("t6_next_burst", bq.size(), nb + 1);
      if (bq.size() > nb) chk("t6_next_len", bq[nb].beats, 16);
`ifdef ARB_STATS_EN
      chk("t6_stat0", longint'(stat_beats[0 +: 32]), 16);
      chk("t6_stat3", longint'(stat_beats[3*32 +: 32]), 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
